// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that launches queued bytes into a UART transmitter one at a time.
// Define UART_TX_FIFO_OVF_EN to add a sticky overflow flag with its ovf_clr input.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              tx_en,
    input  logic              tx_done,
`ifdef UART_TX_FIFO_OVF_EN
    input  logic              ovf_clr,
    output logic              overflow,
`endif
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              busy
);
    localparam int LW = ADDR_W + 1;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;

    logic [1:0]        r_state;
    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [ADDR_W:0]   w_level_nxt;
    logic              r_full, r_empty;
    logic [7:0]        r_tx_data;
    logic              w_push, w_pop;

    // A push into a full FIFO is dropped even when a pop frees a slot on the same edge.
    assign w_push      = wr_en && !r_full;
    assign w_pop       = (r_state == IDLE) && !r_empty && tx_en;
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr_ptr] <= wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_state   <= IDLE;
            r_tx_data <= 8'h00;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
                r_tx_data <= r_mem[r_rd_ptr];
            end
            r_level <= w_level_nxt;
            r_full  <= w_level_nxt == LW'(DEPTH);
            r_empty <= w_level_nxt == '0;
            r_state <= w_pop                         ? LAUNCH :
                       (r_state == LAUNCH)           ? WAIT   :
                       (r_state == WAIT && !tx_done) ? WAIT   : IDLE;
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic r_overflow;
    always_ff @(posedge clk) begin
        if (rst || ovf_clr) r_overflow <= 1'b0;
        else if (wr_en && r_full) r_overflow <= 1'b1;
    end
    assign overflow = r_overflow;
`endif

    assign tx_start = r_state == LAUNCH;
    assign tx_data  = r_tx_data;
    assign full     = r_full;
    assign empty    = r_empty;
    assign level    = r_level;
    assign busy     = !r_empty || r_state != IDLE;
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, FIFO entries (power of two, 2..256).
REQ-002 SHALL provide parameter ADDR_W, default 4, pointer width (log2 DEPTH).
REQ-003 SHALL provide port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port wr_en  input  1  push request from bus register write.
REQ-006 SHALL provide port wr_data  input  8  byte to push.
REQ-007 SHALL provide port tx_en  input  1  permits launching new bytes to the transmitter.
REQ-008 SHALL provide port tx_done  input  1  one-cycle pulse from the transmitter at end of stop bit.
REQ-009 SHALL provide port tx_start  output  1  one-cycle launch pulse to the transmitter.
REQ-010 SHALL provide port tx_data  output  8  byte for the transmitter, held stable from tx_start until tx_done.
REQ-011 SHALL provide port full / empty  output  1 each  FIFO status.
REQ-012 SHALL provide port level  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-013 SHALL provide port busy  output  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-014 Storage SHALL be a DEPTH x 8 circular buffer with ADDR_W-bit read/write pointers that wrap modulo DEPTH.
REQ-015 Push: wr_en=1 and full=0 at an edge SHALL store wr_data at wr_ptr and advance wr_ptr.
REQ-016 A push with full=1 SHALL be dropped, with pointers and contents unchanged, even if a pop occurs in the same cycle.
REQ-017 Simultaneous accepted push and pop SHALL leave level unchanged.
REQ-018 full SHALL equal (level==DEPTH); empty SHALL equal (level==0); both SHALL be registered and never X after reset.
REQ-019 The FSM SHALL have states IDLE, LAUNCH, WAIT.
REQ-020 IDLE->LAUNCH SHALL occur when empty=0 and tx_en=1; this edge pops the head into tx_data and advances rd_ptr.
REQ-021 In LAUNCH, tx_start SHALL be 1 for exactly that one cycle; the next edge SHALL go to WAIT.
REQ-022 WAIT->IDLE SHALL occur on tx_done=1; tx_done seen in IDLE or LAUNCH SHALL be ignored.
REQ-023 Latency: a byte written into an empty FIFO with tx_en=1 SHALL produce tx_start two cycles after the write edge.
REQ-024 Back-to-back bytes SHALL have exactly one IDLE cycle between tx_done and the next LAUNCH.
REQ-025 Deasserting tx_en SHALL NOT abort LAUNCH/WAIT; the current byte completes and no new byte launches.
REQ-026 tx_data SHALL change only on IDLE->LAUNCH edges.

Reset
REQ-027 rst=1 at an edge SHALL clear pointers and level, force FSM to IDLE, and drive tx_start=0, tx_data=8'h00, empty=1, full=0, busy=0.
REQ-028 Reset mid-WAIT SHALL discard all queued bytes; the block SHALL NOT signal the transmitter beyond deasserting tx_start.
REQ-029 Memory contents need not be cleared by reset.

Configuration
REQ-030 Macro UART_TX_FIFO_OVF_EN, when defined, SHALL add output overflow (1 bit): sticky, set by a dropped push, cleared only by rst or by input ovf_clr (1-cycle pulse, priority over set).
REQ-031 Without UART_TX_FIFO_OVF_EN, neither port SHALL exist and dropped pushes SHALL be silent.

Verification
REQ-032 Reset, then push 8'h69 with tx_en=1 -> tx_start pulses 2 cycles later with tx_data=8'h69; busy=1 until tx_done+1.
REQ-033 tx_en=0, push 16 bytes 0x00..0x0F -> full=1, level=16; 17th push 0xAA dropped; overflow=1 if macro is defined.
REQ-034 From full, raise tx_en and return tx_done 10 cycles after each tx_start -> bytes launch in order 0x00..0x0F; empty=1 at end; 0xAA never appears.
REQ-035 Push and pop in the same cycle at level=5 -> level stays 5; pointer wrap is exercised by 40 sequential bytes with order preserved.
REQ-036 Assert rst during WAIT with level=3 -> next cycle level=0, tx_start=0, FSM IDLE; a later tx_done is ignored.
REQ-037 Drop tx_en during WAIT -> current byte completes on tx_done; no further tx_start while tx_en=0.
